// File: rtl/nonce_result_scan_pkg.sv
// Shared definitions for the nonce result scanner and the bitcoin_hash engine.
package nonce_result_scan_pkg;

   localparam int DEFAULT_NUM_NONCE = 16;
   localparam int DEFAULT_NONCE_W   = 4;

   localparam int RESULT_WORDS = 2;
   localparam int FOUND_BIT    = 31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_WR0,
      ST_WR1
   } scan_state_t;

   // Word 0 of the result record: found flag in the MSB, winning index in the low bits.
   function automatic logic [31:0] packRecord0(input logic found, input logic [30:0] winIdx);
      logic [31:0] rec;
      rec            = {1'b0, winIdx};
      rec[FOUND_BIT] = found;
      return rec;
   endfunction

endpackage

// File: rtl/hash_min_cmp.sv
// Single-word compare step: folds one H0 word into the running win/minimum state.
module hash_min_cmp #(
   parameter int NONCE_W = 4
) (
   input  logic [31:0]        h_i,
   input  logic [NONCE_W-1:0] idx_i,
   input  logic [31:0]        target_i,
   input  logic               found_i,
   input  logic [NONCE_W-1:0] winNonce_i,
   input  logic [31:0]        bestHash_i,
   input  logic [NONCE_W-1:0] bestNonce_i,
   output logic               win_o,
   output logic               update_o,
   output logic               found_o,
   output logic [NONCE_W-1:0] winNonce_o,
   output logic [31:0]        bestHash_o,
   output logic [NONCE_W-1:0] bestNonce_o
);

   // Strict compares: equality neither wins nor displaces an earlier minimum.
   always_comb begin
      win_o       = (h_i < target_i) && !found_i;
      update_o    = (h_i < bestHash_i);
      found_o     = found_i | win_o;
      winNonce_o  = win_o ? idx_i : winNonce_i;
      bestHash_o  = update_o ? h_i : bestHash_i;
      bestNonce_o = update_o ? idx_i : bestNonce_i;
   end

endmodule

// File: rtl/nonce_result_scan.sv
// Scans the engine's final H0 words, finds the first below target and the minimum,
// and writes a two-word result record back to shared memory.
module nonce_result_scan
   import nonce_result_scan_pkg::*;
#(
   parameter int NUM_NONCE = DEFAULT_NUM_NONCE,
   parameter int NONCE_W   = DEFAULT_NONCE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [15:0]        hash_addr,
   input  logic [15:0]        result_addr,
   input  logic [31:0]        target,
   output logic               done,
   output logic               found,
   output logic [NONCE_W-1:0] win_nonce,
   output logic [NONCE_W-1:0] best_nonce,
   output logic [31:0]        best_hash,
   output logic               mem_clk,
   output logic               mem_we,
   output logic [15:0]        mem_addr,
   output logic [31:0]        mem_write_data,
   input  logic [31:0]        mem_read_data
);

   scan_state_t        state_q;
   logic [NONCE_W-1:0] rdCtr_q;
   logic [15:0]        hashBase_q;
   logic [15:0]        resultBase_q;
   logic [31:0]        target_q;
   logic               found_q;
   logic [NONCE_W-1:0] winNonce_q;
   logic [NONCE_W-1:0] bestNonce_q;
   logic [31:0]        bestHash_q;
   logic               done_q;
   logic               memWe_q;
   logic [15:0]        memAddr_q;
   logic [31:0]        memWriteData_q;

   logic [NONCE_W-1:0] cmpIdx;
   logic               cmpWin;
   logic               cmpUpdate;
   logic               found_d;
   logic [NONCE_W-1:0] winNonce_d;
   logic [31:0]        bestHash_d;
   logic [NONCE_W-1:0] bestNonce_d;

   localparam logic [NONCE_W-1:0] LAST_IDX = NONCE_W'(NUM_NONCE - 1);

   // Read data lags the address by one cycle, so the word under compare is one behind rdCtr.
   always_comb begin
      cmpIdx = (state_q == ST_DRAIN) ? LAST_IDX : (rdCtr_q - NONCE_W'(1));
   end

   hash_min_cmp #(
      .NONCE_W (NONCE_W)
   ) u_cmp (
      .h_i         (mem_read_data),
      .idx_i       (cmpIdx),
      .target_i    (target_q),
      .found_i     (found_q),
      .winNonce_i  (winNonce_q),
      .bestHash_i  (bestHash_q),
      .bestNonce_i (bestNonce_q),
      .win_o       (cmpWin),
      .update_o    (cmpUpdate),
      .found_o     (found_d),
      .winNonce_o  (winNonce_d),
      .bestHash_o  (bestHash_d),
      .bestNonce_o (bestNonce_d)
   );

   // Scan FSM: issue reads, fold results, then write the record; all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rdCtr_q        <= '0;
         hashBase_q     <= '0;
         resultBase_q   <= '0;
         target_q       <= '0;
         found_q        <= 1'b0;
         winNonce_q     <= '0;
         bestNonce_q    <= '0;
         bestHash_q     <= 32'hFFFF_FFFF;
         done_q         <= 1'b0;
         memWe_q        <= 1'b0;
         memAddr_q      <= '0;
         memWriteData_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  hashBase_q   <= hash_addr;
                  resultBase_q <= result_addr;
                  target_q     <= target;
                  rdCtr_q      <= '0;
                  found_q      <= 1'b0;
                  winNonce_q   <= '0;
                  bestNonce_q  <= '0;
                  bestHash_q   <= 32'hFFFF_FFFF;
                  memAddr_q    <= hash_addr;
                  state_q      <= ST_READ;
               end
            end
            ST_READ: begin
               if (rdCtr_q != '0) begin
                  found_q     <= found_d;
                  winNonce_q  <= winNonce_d;
                  bestHash_q  <= bestHash_d;
                  bestNonce_q <= bestNonce_d;
               end
               if (rdCtr_q == LAST_IDX) begin
                  state_q <= ST_DRAIN;
               end else begin
                  rdCtr_q   <= rdCtr_q + NONCE_W'(1);
                  memAddr_q <= hashBase_q + 16'(rdCtr_q) + 16'd1;
               end
            end
            ST_DRAIN: begin
               found_q        <= found_d;
               winNonce_q     <= winNonce_d;
               bestHash_q     <= bestHash_d;
               bestNonce_q    <= bestNonce_d;
               memWe_q        <= 1'b1;
               memAddr_q      <= resultBase_q;
               memWriteData_q <= packRecord0(found_d, 31'(winNonce_d));
               state_q        <= ST_WR0;
            end
            ST_WR0: begin
               memAddr_q      <= resultBase_q + 16'd1;
               memWriteData_q <= bestHash_q;
               done_q         <= 1'b1;
               state_q        <= ST_WR1;
            end
            ST_WR1: begin
               memWe_q <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign done           = done_q;
   assign found          = found_q;
   assign win_nonce      = winNonce_q;
   assign best_nonce     = bestNonce_q;
   assign best_hash      = bestHash_q;
   assign mem_clk        = clk;
   assign mem_we         = memWe_q;
   assign mem_addr       = memAddr_q;
   assign mem_write_data = memWriteData_q;

endmodule
